// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions for the fetch stage: datapath width,
//                default reset PC, instruction word size, fetch FSM encoding
//                and a sequential-PC helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int              INSTR_WORD_BYTES = 4;

    // FETCH: request outstanding for PCF
    // DRAIN: stale request outstanding, its data is thrown away
    // HOLD : a fetched word is parked behind a decode stall
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Sequential successor; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus_word(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_WORD_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/response bus.
//  Signals     : req   - fetch request
//                addr  - word address of the outstanding fetch
//                ready - data valid this cycle, completes the request
//                rdata - instruction word (valid with ready)
//  Modports    : master (fetch stage), slave (instruction memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import cpu_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input  ready, rdata);
    modport slave  (input  req, addr, output ready, rdata);

endinterface
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hold_buffer
//  Description : One-entry skid register that parks a fetched instruction,
//                its PC and its prediction bit while decode is stalled.
//  Ports       : clk, reset       - clock, async active-high reset
//                load, clear      - capture new entry / drop entry
//                in_instr/in_pc/in_pred - entry contents to capture
//                instr/pc/pred/valid    - stored entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buffer
    import cpu_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            load,
    input  wire logic            clear,
    input  wire logic [XLEN-1:0] in_instr,
    input  wire logic [XLEN-1:0] in_pc,
    input  wire logic            in_pred,
    output logic      [XLEN-1:0] instr,
    output logic      [XLEN-1:0] pc,
    output logic                 pred,
    output logic                 valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_pred;
    logic            r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_pred  <= 1'b0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_instr <= in_instr;
            r_pc    <= in_pc;
            r_pred  <= in_pred;
            r_valid <= 1'b1;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign instr = r_instr;
    assign pc    = r_pc;
    assign pred  = r_pred;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage with IF/ID pipeline register.
//                Next PC priority: Redirect > predicted-taken > PCF+4.
//                A redirect while a request is pending moves to DRAIN so the
//                stale response is consumed and discarded; a word that
//                returns under StallD is parked in a hold buffer.
//  Config      : FETCH_PREDICT_EN - when defined, PredPC/PredTaken steer the
//                next PC and PredTakenD follows PredTaken; otherwise they are
//                ignored and PredTakenD is 0.
//  Ports       : clk, reset (async, active high); imem (master bus);
//                PredPC/PredTaken, Redirect/RedirectPC, StallD in;
//                PCF, InstrD, PCD, PCPlus4D, ValidD, PredTakenD out.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fetch_stage_if.master        imem,
    input  wire logic [XLEN-1:0] PredPC,
    input  wire logic            PredTaken,
    input  wire logic            Redirect,
    input  wire logic [XLEN-1:0] RedirectPC,
    input  wire logic            StallD,
    output logic      [XLEN-1:0] PCF,
    output logic      [XLEN-1:0] InstrD,
    output logic      [XLEN-1:0] PCD,
    output logic      [XLEN-1:0] PCPlus4D,
    output logic                 ValidD,
    output logic                 PredTakenD
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] r_drain_addr;
    logic [XLEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic            r_valid_d;
    logic            r_pred_d;

    logic [XLEN-1:0] w_buf_instr;
    logic [XLEN-1:0] w_buf_pc;
    logic            w_buf_pred;
    logic            w_buf_valid;

    logic            w_pred_live;
    logic            w_use_pred;
    logic [XLEN-1:0] w_next_pc;
    logic            w_deliver_fetch;
    logic            w_capture;
    logic            w_release;
    logic            w_buf_clear;

`ifdef FETCH_PREDICT_EN
    assign w_pred_live = PredTaken;
`else
    assign w_pred_live = 1'b0;
    logic  w_unused_pred;
    assign w_unused_pred = &{1'b0, PredTaken};
`endif

    // While holding, PCF is the parked PC, so the predictor target still
    // matches; only the taken bit is taken from the buffer.
    assign w_use_pred = (r_state == ST_HOLD) ? w_buf_pred : w_pred_live;
    assign w_next_pc  = w_use_pred ? PredPC : pc_plus_word(r_pcf);

    assign w_deliver_fetch = (r_state == ST_FETCH) && imem.ready && !StallD && !Redirect;
    assign w_capture       = (r_state == ST_FETCH) && imem.ready &&  StallD && !Redirect;
    assign w_release       = (r_state == ST_HOLD)  && w_buf_valid && !StallD && !Redirect;
    assign w_buf_clear     = (r_state == ST_HOLD)  && (Redirect || !StallD);

    fetch_hold_buffer u_hold_buffer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_capture),
        .clear    (w_buf_clear),
        .in_instr (imem.rdata),
        .in_pc    (r_pcf),
        .in_pred  (w_pred_live),
        .instr    (w_buf_instr),
        .pc       (w_buf_pc),
        .pred     (w_buf_pred),
        .valid    (w_buf_valid)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (Redirect)                    w_state_next = imem.ready ? ST_FETCH : ST_DRAIN;
                else if (imem.ready && StallD)   w_state_next = ST_HOLD;
            end
            ST_DRAIN: if (imem.ready)            w_state_next = ST_FETCH;
            ST_HOLD:  if (Redirect || !StallD)   w_state_next = ST_FETCH;
            default:                             w_state_next = ST_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // In DRAIN the bus must keep presenting the abandoned address until it
    // completes, while PCF already holds the redirect target.
    always_comb begin
        imem.req  = !reset && (r_state != ST_HOLD);
        imem.addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pcf;
    end

    // ---------------- PC registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf        <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            if (Redirect)
                r_pcf <= RedirectPC;
            else if (w_deliver_fetch || w_release)
                r_pcf <= w_next_pc;
            if ((r_state == ST_FETCH) && Redirect && !imem.ready)
                r_drain_addr <= r_pcf;
        end
    end

    // ---------------- IF/ID register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_d <= '0;
            r_pc_d    <= '0;
            r_valid_d <= 1'b0;
            r_pred_d  <= 1'b0;
        end else if (Redirect) begin
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_deliver_fetch) begin
                r_instr_d <= imem.rdata;
                r_pc_d    <= r_pcf;
                r_pred_d  <= w_pred_live;
                r_valid_d <= 1'b1;
            end else if (w_release) begin
                r_instr_d <= w_buf_instr;
                r_pc_d    <= w_buf_pc;
                r_pred_d  <= w_buf_pred;
                r_valid_d <= 1'b1;
            end else begin
                r_valid_d <= 1'b0;
            end
        end
    end

    assign PCF        = r_pcf;
    assign InstrD     = r_instr_d;
    assign PCD        = r_pc_d;
    // A reset IF/ID register reads all zero, including PCPlus4D.
    assign PCPlus4D   = (r_valid_d || (r_pc_d != '0)) ? pc_plus_word(r_pc_d) : '0;
    assign ValidD     = r_valid_d;
    assign PredTakenD = r_pred_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Table-driven directed bench for fetch_stage plus a reset
//                sequence exercised in the middle of a HOLD.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PredPC, RedirectPC;
    logic        PredTaken, Redirect, StallD;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, PredTakenD;

    always #5 clk = ~clk;

    fetch_stage_if imem();

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (imem.master),
        .PredPC     (PredPC),
        .PredTaken  (PredTaken),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .StallD     (StallD),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .PredTakenD (PredTakenD)
    );

`ifdef FETCH_PREDICT_EN
    localparam logic        PEN  = 1'b1;
    localparam logic [31:0] NXT  = 32'h0000_0200;
`else
    localparam logic        PEN  = 1'b0;
    localparam logic [31:0] NXT  = 32'h0000_0054;
`endif

    typedef struct {
        logic        rdy, stall, redir;
        logic [31:0] rpc;
        logic        ptk;
        logic [31:0] ppc;
        logic        req;
        logic [31:0] addr, pcf;
        logic        vld;
        logic [31:0] pcd;
        logic        ptd;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic rdy, stall, redir, input logic [31:0] rpc,
                                input logic ptk, input logic [31:0] ppc,
                                input logic req, input logic [31:0] addr, pcf,
                                input logic vld, input logic [31:0] pcd, input logic ptd);
        vec_t v;
        v.rdy = rdy; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.ptk = ptk; v.ppc = ppc; v.req = req; v.addr = addr; v.pcf = pcf;
        v.vld = vld; v.pcd = pcd; v.ptd = ptd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, stall, redir, input logic [31:0] rpc,
                         input logic ptk, input logic [31:0] ppc, input logic [31:0] addr);
        imem.ready = rdy;
        imem.rdata = rdy ? mem(addr) : 32'hDEAD_DEAD;
        StallD     = stall;
        Redirect   = redir;
        RedirectPC = rpc;
        PredTaken  = ptk;
        PredPC     = ppc;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        //  rdy st rd rpc            ptk ppc   | req addr          pcf           vld pcd           ptd
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h00,32'h00, 1,32'h00,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h04,32'h04, 1,32'h04,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h08,32'h08, 1,32'h08,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h0C,32'h0C, 1,32'h0C,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h10,32'h10, 0,32'h0C,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h10,32'h10, 0,32'h0C,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h10,32'h10, 0,32'h0C,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h10,32'h10, 1,32'h10,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h14,32'h14, 1,32'h14,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h18,32'h18, 1,32'h18,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h1C,32'h1C, 1,32'h1C,0));
        vecs.push_back(mk(1,1,0,0,0,0, 1,32'h20,32'h20, 1,32'h1C,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,32'h20,32'h20, 1,32'h1C,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,32'h20,32'h20, 1,32'h20,0));
        vecs.push_back(mk(1,0,1,32'h40,0,0, 1,32'h24,32'h24, 0,32'h20,0));
        vecs.push_back(mk(0,0,1,32'h100,0,0, 1,32'h40,32'h40, 0,32'h20,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h40,32'h100, 0,32'h20,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h40,32'h100, 0,32'h20,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h100,32'h100, 1,32'h100,0));
        vecs.push_back(mk(1,0,1,32'h50,0,0, 1,32'h104,32'h104, 0,32'h100,0));
        vecs.push_back(mk(1,0,0,0,1,32'h200, 1,32'h50,32'h50, 1,32'h50,PEN));
        vecs.push_back(mk(1,0,0,0,0,0, 1,NXT,NXT, 1,NXT,0));
        vecs.push_back(mk(1,0,1,32'hFFFF_FFFC,0,0, 1,NXT+32'h4,NXT+32'h4, 0,NXT,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'hFFFF_FFFC,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h00,32'h00, 1,32'h00,0));
        vecs.push_back(mk(0,1,1,32'h300,0,0, 1,32'h04,32'h04, 0,32'h00,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h04,32'h300, 0,32'h00,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h300,32'h300, 1,32'h300,0));
        vecs.push_back(mk(1,0,1,32'h7C,0,0, 1,32'h304,32'h304, 0,32'h300,0));

        // ---- reset state ----
        #1 reset = 1'b1;
        #2;
        chk("rst_req",    imem.req,   32'd0);
        chk("rst_pcf",    PCF,        32'd0);
        chk("rst_valid",  ValidD,     32'd0);
        chk("rst_instr",  InstrD,     32'd0);
        chk("rst_pcd",    PCD,        32'd0);
        chk("rst_pcp4",   PCPlus4D,   32'd0);
        chk("rst_ptd",    PredTakenD, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                  vecs[i].ptk, vecs[i].ppc, vecs[i].addr);
            #1;
            chk($sformatf("v%0d_req", i), imem.req, vecs[i].req);
            if (vecs[i].req) chk($sformatf("v%0d_addr", i), imem.addr, vecs[i].addr);
            chk($sformatf("v%0d_pcf", i), PCF, vecs[i].pcf);
            @(posedge clk); #1;
            chk($sformatf("v%0d_validd", i), ValidD, vecs[i].vld);
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_instrd", i), InstrD,     mem(vecs[i].pcd));
                chk($sformatf("v%0d_pcd", i),    PCD,        vecs[i].pcd);
                chk($sformatf("v%0d_pcp4", i),   PCPlus4D,   vecs[i].pcd + 32'h4);
                chk($sformatf("v%0d_ptd", i),    PredTakenD, vecs[i].ptd);
            end
        end

        // ---- reset in the middle of HOLD at PCF=0x80 ----
        drive(1, 0, 0, 0, 0, 0, 32'h7C);
        @(posedge clk); #1;
        chk("h_valid7c", ValidD, 32'd1);
        chk("h_pcf80",   PCF,    32'h80);
        drive(1, 1, 0, 0, 0, 0, 32'h80);
        #1 chk("h_addr80", imem.addr, 32'h80);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 32'h80);
        #1;
        chk("h_req_hold", imem.req, 32'd0);
        chk("h_pcf_hold", PCF,      32'h80);
        chk("h_valid_hold", ValidD, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("h_rst_valid", ValidD,   32'd0);
        chk("h_rst_req",   imem.req, 32'd0);
        chk("h_rst_pcf",   PCF,      32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("h_rel_req",  imem.req,  32'd1);
        chk("h_rel_addr", imem.addr, 32'h0);
        @(posedge clk); #1;
        chk("h_rel_valid", ValidD, 32'd1);
        chk("h_rel_instr", InstrD, mem(32'h0));
        chk("h_rel_pcf",   PCF,    32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PCF value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction fetch request to instruction memory.
REQ-005 imem_addr  output  32  word address of the outstanding fetch.
REQ-006 imem_ready  input  1  fetch data valid this cycle; completes the request.
REQ-007 imem_rdata  input  32  instruction word, sampled only when imem_ready=1.
REQ-008 PredPC  input  32  predictor next-PC for the current PCF.
REQ-009 PredTaken  input  1  predictor marks PredPC as taken.
REQ-010 Redirect  input  1  mispredict/branch resolution; overrides all other next-PC sources.
REQ-011 RedirectPC  input  32  corrected fetch address.
REQ-012 StallD  input  1  decode stall from hazard unit; holds IF/ID.
REQ-013 PCF  output  32  current fetch PC, drives predictor lookup.
REQ-014 InstrD, PCD, PCPlus4D  output  32 each  IF/ID register contents.
REQ-015 ValidD, PredTakenD  output  1 each  IF/ID valid; prediction used for InstrD.

Function
REQ-016 States SHALL be FETCH (request outstanding for PCF), DRAIN (stale request outstanding, data discarded), HOLD (instruction buffered behind StallD).
REQ-017 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD; imem_addr SHALL stay constant until the cycle imem_ready=1.
REQ-018 Same-cycle completion SHALL be supported: imem_ready may be 1 in the first request cycle.
REQ-019 Next PC priority: Redirect -> RedirectPC; else PredTaken -> PredPC; else PCF+4 (mod 2^32, wrap at 32'hFFFF_FFFC to 0).
REQ-020 FETCH & imem_ready & !StallD & !Redirect: IF/ID <= {imem_rdata, PCF, PCF+4, PredTaken}, ValidD<=1, PCF<=next PC, stay FETCH.
REQ-021 FETCH & imem_ready & StallD & !Redirect: word, PCF, PredTaken captured in hold buffer, PCF held, go HOLD.
REQ-022 HOLD & !StallD & !Redirect: buffer moves to IF/ID, ValidD<=1, PCF<=next PC computed from held prediction, go FETCH.
REQ-023 Redirect in FETCH with imem_ready=0: PCF<=RedirectPC, go DRAIN; imem_addr keeps stale address.
REQ-024 Redirect in FETCH with imem_ready=1, or in HOLD: data/buffer discarded, PCF<=RedirectPC, go FETCH.
REQ-025 DRAIN & imem_ready: data discarded, go FETCH for PCF; Redirect during DRAIN only updates PCF.
REQ-026 Redirect SHALL clear ValidD next cycle regardless of StallD.
REQ-027 StallD=1 (no Redirect) SHALL hold all IF/ID outputs unchanged.
REQ-028 !StallD with no instruction delivered SHALL load ValidD<=0 (bubble); other IF/ID fields hold.
REQ-029 Latency: instruction visible on InstrD one cycle after its imem_ready cycle when unstalled.

Reset
REQ-030 Reset SHALL force: state FETCH, PCF=RESET_PC, ValidD=0, PredTakenD=0, InstrD=PCD=PCPlus4D=0, hold buffer empty, imem_req=0 while reset asserted.
REQ-031 Reset mid-request SHALL abandon it; first request after release targets RESET_PC.

Configuration
REQ-032 Macro FETCH_PREDICT_EN defined: REQ-019 prediction path active, PredTakenD reflects PredTaken.
REQ-033 Macro undefined: PredPC/PredTaken ignored, next PC is Redirect or PCF+4, PredTakenD tied 0.

Structure
REQ-034 Shared package cpu_pkg SHALL hold fetch state enum, XLEN=32, default RESET_PC, INSTR_WORD_BYTES=4.
REQ-035 One sub-module fetch_hold_buffer (1-entry skid register: instr, PC, pred bit, valid) is natural; rest inline.

Verification
REQ-036 Zero-wait memory, no stall/redirect, reset release -> imem_addr 0,4,8,12 on consecutive cycles; ValidD=1 from cycle 2.
REQ-037 imem_ready delayed 3 cycles at PCF=0x10 -> imem_addr stable 0x10 three cycles; ValidD=0 bubbles; InstrD loads the cycle after ready.
REQ-038 StallD=1 for 2 cycles when word at 0x20 returns -> state HOLD, PCF stays 0x20, no request; on release InstrD=word@0x20, PCF=0x24.
REQ-039 Redirect to 0x100 while request to 0x40 pending -> DRAIN, returning 0x40 word never reaches InstrD; next request 0x100; ValidD=0 meanwhile.
REQ-040 FETCH_PREDICT_EN defined, PCF=0x50, PredTaken=1, PredPC=0x200 -> next imem_addr 0x200, PredTakenD=1; undefined -> 0x54, PredTakenD=0.
REQ-041 Reset asserted mid-HOLD with PCF=0x80 -> ValidD=0 immediately, after release imem_addr=RESET_PC.
